// File: rtl/ball_pkg.sv
// Purpose : shared types/constants for the ball tracker (FSM encoding, map codes, screen bounds).
// Latency : n/a (package only).
// Backpress: n/a (package only).
package ball_pkg;

    // Move-evaluation sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        X_QRY  = 3'd1,
        X_WAIT = 3'd2,
        Y_QRY  = 3'd3,
        Y_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Map location codes returned on wrld_loc_info.
    localparam logic [1:0] MAP_FREE = 2'd0;
    localparam logic [1:0] MAP_WALL = 2'd2;

    // Default VGA-style screen geometry.
    localparam int SCREEN_X_WIDTH = 10;
    localparam int SCREEN_Y_WIDTH = 9;
    localparam int SCREEN_X_MAX   = 639;
    localparam int SCREEN_Y_MAX   = 479;

endpackage

// File: rtl/tick_gen.sv
// Purpose : free-running divider, one-cycle tick when the counter sits at TOP_CNT (period TOP_CNT+1).
// Latency : first tick TOP_CNT+1 cycles after reset release (counter starts at 0).
// Backpress: none; tick is a fire-and-forget strobe.
// Ports   : clk, reset (async active-low), tick (out, 1 cycle wide).
module tick_gen #(
    parameter int          CNTR_WIDTH = 32,
    parameter int unsigned TOP_CNT    = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNTR_WIDTH-1:0] TOP = CNTR_WIDTH'(TOP_CNT);

    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TOP);
        cnt_d = tick ? '0 : cnt_q + CNTR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ball_tracker.sv
// Purpose : moves a ball on each update tick, querying an external map so walls block motion per axis.
// Latency : tick at T -> update_done at T+6 with MAP_LATENCY=1 and both axes moving; skipped axes shorten it.
// Backpress: ticks arriving while busy are dropped and flagged on sticky tick_overrun.
// Ports   : clk/reset (async active-low); x/y inc/dec + step requests; wrld_col/row_addr out, wrld_loc_info in;
//           x_out/y_out committed position; busy, update_done pulse, blocked {y,x}, tick_overrun.
module ball_tracker
    import ball_pkg::*;
#(
    parameter int          CLK_FREQUENCY_HZ       = 100000000,
    parameter int          UPDATE_FREQUENCY_HZ    = 30,
    parameter int          CNTR_WIDTH             = 32,
    parameter int          SIMULATE               = 0,
    parameter int          SIMULATE_FREQUENCY_CNT = 5,
    parameter int          X_WIDTH                = SCREEN_X_WIDTH,
    parameter int          Y_WIDTH                = SCREEN_Y_WIDTH,
    parameter int          X_MAX                  = SCREEN_X_MAX,
    parameter int          Y_MAX                  = SCREEN_Y_MAX,
    parameter int          X_INIT                 = 0,
    parameter int          Y_INIT                 = 0,
    parameter int          STEP_WIDTH             = 3,
    parameter logic [1:0]  WALL_CODE              = MAP_WALL,
    parameter int          MAP_LATENCY            = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x_increment,
    input  logic                  x_decrement,
    input  logic                  y_increment,
    input  logic                  y_decrement,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [X_WIDTH-1:0]    wrld_col_addr,
    output logic [Y_WIDTH-1:0]    wrld_row_addr,
    input  logic [1:0]            wrld_loc_info,
    output logic [X_WIDTH-1:0]    x_out,
    output logic [Y_WIDTH-1:0]    y_out,
    output logic                  busy,
    output logic                  update_done,
    output logic [1:0]            blocked,
    output logic                  tick_overrun
);

    localparam int unsigned TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                      : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;
    localparam int XW1 = X_WIDTH + 1;
    localparam int YW1 = Y_WIDTH + 1;

    logic tick;

    tick_gen #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .TOP_CNT    (TOP_CNT)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_t               state_q,    state_d;
    logic [X_WIDTH-1:0]   x_q,        x_d;
    logic [Y_WIDTH-1:0]   y_q,        y_d;
    logic [X_WIDTH-1:0]   cand_x_q,   cand_x_d;
    logic [Y_WIDTH-1:0]   cand_y_q,   cand_y_d;
    logic [2:0]           wait_q,     wait_d;
    logic                 blk_x_q,    blk_x_d;
    logic                 blk_y_q,    blk_y_d;
    logic [1:0]           blocked_q,  blocked_d;
    logic                 done_q,     done_d;
    logic                 overrun_q,  overrun_d;

    // Candidate positions from the live requests; only consumed on the IDLE tick.
    // One extra bit catches overflow above the bound and borrow below zero.
    logic [X_WIDTH:0]     x_ext, x_stp, x_sum, x_dif;
    logic [Y_WIDTH:0]     y_ext, y_stp, y_sum, y_dif;
    logic [X_WIDTH-1:0]   x_next;
    logic [Y_WIDTH-1:0]   y_next;

    always_comb begin
        x_ext  = {1'b0, x_q};
        x_stp  = XW1'(step);
        x_sum  = x_ext + x_stp;
        x_dif  = x_ext - x_stp;
        x_next = x_q;
        if (x_increment && !x_decrement) begin
            x_next = (x_sum > XW1'(X_MAX)) ? X_WIDTH'(X_MAX) : x_sum[X_WIDTH-1:0];
        end else if (x_decrement && !x_increment) begin
            x_next = x_dif[X_WIDTH] ? '0 : x_dif[X_WIDTH-1:0];
        end

        y_ext  = {1'b0, y_q};
        y_stp  = YW1'(step);
        y_sum  = y_ext + y_stp;
        y_dif  = y_ext - y_stp;
        y_next = y_q;
        if (y_increment && !y_decrement) begin
            y_next = (y_sum > YW1'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : y_sum[Y_WIDTH-1:0];
        end else if (y_decrement && !y_increment) begin
            y_next = y_dif[Y_WIDTH] ? '0 : y_dif[Y_WIDTH-1:0];
        end
    end

    // Sequencer: X is resolved and committed before Y is queried, so Y's
    // query uses the updated column and the ball slides along walls.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        wait_d    = wait_q;
        blk_x_d   = blk_x_q;
        blk_y_d   = blk_y_q;
        blocked_d = blocked_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (tick) begin
                    cand_x_d = x_next;
                    cand_y_d = y_next;
                    blk_x_d  = 1'b0;
                    blk_y_d  = 1'b0;
                    if (x_next != x_q) begin
                        state_d = X_QRY;
                    end else if (y_next != y_q) begin
                        state_d = Y_QRY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            X_QRY: begin
                // The query cycle itself counts as the first latency cycle.
                wait_d  = 3'd1;
                state_d = X_WAIT;
            end
            X_WAIT: begin
                if (wait_q == 3'(MAP_LATENCY)) begin
                    if (wrld_loc_info == WALL_CODE) begin
                        blk_x_d = 1'b1;
                    end else begin
                        x_d = cand_x_q;
                    end
                    state_d = (cand_y_q != y_q) ? Y_QRY : DONE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            Y_QRY: begin
                wait_d  = 3'd1;
                state_d = Y_WAIT;
            end
            Y_WAIT: begin
                if (wait_q == 3'(MAP_LATENCY)) begin
                    if (wrld_loc_info == WALL_CODE) begin
                        blk_y_d = 1'b1;
                    end else begin
                        y_d = cand_y_q;
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                blocked_d = {blk_y_q, blk_x_q};
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Map address follows the axis under evaluation; otherwise the committed position.
    always_comb begin
        wrld_col_addr = x_q;
        wrld_row_addr = y_q;
        case (state_q)
            X_QRY, X_WAIT: wrld_col_addr = cand_x_q;
            Y_QRY, Y_WAIT: wrld_row_addr = cand_y_q;
            default: begin
                wrld_col_addr = x_q;
                wrld_row_addr = y_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            x_q       <= X_WIDTH'(X_INIT);
            y_q       <= Y_WIDTH'(Y_INIT);
            cand_x_q  <= X_WIDTH'(X_INIT);
            cand_y_q  <= Y_WIDTH'(Y_INIT);
            wait_q    <= 3'd0;
            blk_x_q   <= 1'b0;
            blk_y_q   <= 1'b0;
            blocked_q <= 2'b00;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            wait_q    <= wait_d;
            blk_x_q   <= blk_x_d;
            blk_y_q   <= blk_y_d;
            blocked_q <= blocked_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign busy         = (state_q != IDLE);
    assign update_done  = done_q;
    assign blocked      = blocked_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_ball_tracker.sv
// Purpose : self-checking bench for ball_tracker; scoreboard of expected positions per update_done.
// Latency : n/a.
// Backpress: n/a.
module tb_ball_tracker;
    import ball_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // ---------------- instance A: main scenarios ----------------
    logic       xi = 0, xd = 0, yi = 0, yd = 0;
    logic [2:0] step = '0;
    logic [9:0] col_a;
    logic [8:0] row_a;
    logic [1:0] loc_a = MAP_FREE;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic       busy_a, done_a, ovr_a;
    logic [1:0] blk_a;
    logic       wall_a_en = 1'b0;

    ball_tracker #(
        .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(5), .MAP_LATENCY(1)
    ) dut (
        .clk(clk), .reset(rst_n),
        .x_increment(xi), .x_decrement(xd), .y_increment(yi), .y_decrement(yd),
        .step(step),
        .wrld_col_addr(col_a), .wrld_row_addr(row_a), .wrld_loc_info(loc_a),
        .x_out(x_a), .y_out(y_a), .busy(busy_a), .update_done(done_a),
        .blocked(blk_a), .tick_overrun(ovr_a)
    );

    // Map A: one-cycle registered lookup, single wall at (13,10) when enabled.
    always @(posedge clk)
        loc_a <= (wall_a_en && col_a == 10'd13 && row_a == 9'd10) ? MAP_WALL : MAP_FREE;

    // ---------------- instance B: slow map, fast ticks ----------------
    logic       xi_b = 0;
    logic [2:0] step_b = '0;
    logic [9:0] col_b, cb1 = '0, cb2 = '0;
    logic [8:0] row_b, rb1 = '0, rb2 = '0;
    logic [1:0] loc_b = MAP_FREE;
    logic [9:0] x_b;
    logic [8:0] y_b;
    logic       busy_b, done_b, ovr_b;
    logic [1:0] blk_b;

    ball_tracker #(
        .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(2), .MAP_LATENCY(3)
    ) dut_b (
        .clk(clk), .reset(rst_n),
        .x_increment(xi_b), .x_decrement(1'b0), .y_increment(1'b0), .y_decrement(1'b0),
        .step(step_b),
        .wrld_col_addr(col_b), .wrld_row_addr(row_b), .wrld_loc_info(loc_b),
        .x_out(x_b), .y_out(y_b), .busy(busy_b), .update_done(done_b),
        .blocked(blk_b), .tick_overrun(ovr_b)
    );

    // Map B: three-cycle pipelined lookup, wall at (4,0).
    always @(posedge clk) begin
        cb1   <= col_b;  rb1 <= row_b;
        cb2   <= cb1;    rb2 <= rb1;
        loc_b <= (cb2 == 10'd4 && rb2 == 9'd0) ? MAP_WALL : MAP_FREE;
    end

    // ---------------- scoreboard and model ----------------
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] blk;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mx = 0, my = 0;
    int   bxm = 0;

    // Counts cycles where A's column address differs from x_out while busy (an X query).
    int   xq_cnt = 0;
    always @(negedge clk) if (busy_a && col_a !== x_a) xq_cnt++;

    function automatic int axis_next(input int pos, input bit inc, input bit dec,
                                     input int st, input int maxv);
        if (inc && !dec) return (pos + st > maxv) ? maxv : pos + st;
        if (dec && !inc) return (pos - st < 0) ? 0 : pos - st;
        return pos;
    endfunction

    function automatic bit wall_a(input int c, input int r);
        return wall_a_en && c == 13 && r == 10;
    endfunction

    task automatic wait_done_a(output bit ok);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done_a && n < 200);
        ok = done_a;
    endtask

    task automatic do_move_a(input bit i_xi, input bit i_xd, input bit i_yi, input bit i_yd,
                             input int st, input string name);
        exp_t e, got;
        int   cx, cy;
        bit   bx, by, ok;
        xi = i_xi; xd = i_xd; yi = i_yi; yd = i_yd; step = 3'(st);
        cx = axis_next(mx, i_xi, i_xd, st, 639);
        bx = 0;
        if (cx != mx) begin if (wall_a(cx, my)) bx = 1; else mx = cx; end
        cy = axis_next(my, i_yi, i_yd, st, 479);
        by = 0;
        if (cy != my) begin if (wall_a(mx, cy)) by = 1; else my = cy; end
        e.x = 10'(mx); e.y = 9'(my); e.blk = {by, bx};
        sb_a.push_back(e);
        wait_done_a(ok);
        e = sb_a.pop_front();
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: update_done timeout, required x=%0d y=%0d", name, e.x, e.y);
        end else begin
            got = {x_a, y_a, blk_a};
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got x=%0d y=%0d blk=%b, required x=%0d y=%0d blk=%b",
                         name, x_a, y_a, blk_a, e.x, e.y, e.blk);
            end
        end
    endtask

    task automatic goto_a(input int tx, input int ty);
        int d;
        while (my != ty) begin
            d = ty - my;
            if (d > 0) do_move_a(0, 0, 1, 0, (d > 7) ? 7 : d, "goto_y");
            else       do_move_a(0, 0, 0, 1, (-d > 7) ? 7 : -d, "goto_y");
        end
        while (mx != tx) begin
            d = tx - mx;
            if (d > 0) do_move_a(1, 0, 0, 0, (d > 7) ? 7 : d, "goto_x");
            else       do_move_a(0, 1, 0, 0, (-d > 7) ? 7 : -d, "goto_x");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({x_a, y_a, busy_a, done_a, blk_a, ovr_a} !== '0) begin
            n_err++;
            $display("FAIL reset_a_outputs: got x=%0d y=%0d busy=%b done=%b blk=%b ovr=%b, required all 0",
                     x_a, y_a, busy_a, done_a, blk_a, ovr_a);
        end
        n_cmp++;
        if ({col_a, row_a} !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got col=%0d row=%0d, required 0/0", col_a, row_a);
        end
        n_cmp++;
        if ({x_b, busy_b, ovr_b} !== '0) begin
            n_err++;
            $display("FAIL reset_b_outputs: got x=%0d busy=%b ovr=%b, required 0", x_b, busy_b, ovr_b);
        end
    endtask

    task automatic test_first_tick;
        exp_t e;
        bit   ok;
        e = '0;
        sb_a.push_back(e);
        rst_n = 1'b1;                       // released mid-cycle at a negedge
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL first_tick_early: got busy=%b after 5 cycles, required 0", busy_a);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL first_tick_on_time: got busy=%b after 6 cycles, required 1", busy_a);
        end
        wait_done_a(ok);
        e = sb_a.pop_front();
        n_cmp++;
        if (!ok || {x_a, y_a, blk_a} !== e) begin
            n_err++;
            $display("FAIL first_tick_null_move: got done=%b x=%0d y=%0d blk=%b, required done=1 x=0 y=0 blk=00",
                     done_a, x_a, y_a, blk_a);
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 3; i++) do_move_a(1, 0, 0, 0, 3, "basic_xinc");
        n_cmp++;
        if ({x_a, y_a, blk_a} !== {10'd9, 9'd0, 2'b00}) begin
            n_err++;
            $display("FAIL basic_final: got x=%0d y=%0d blk=%b, required x=9 y=0 blk=00", x_a, y_a, blk_a);
        end
    endtask

    task automatic test_dec_sat;
        do_move_a(0, 1, 0, 0, 7, "dec_to_2");
        do_move_a(0, 1, 0, 0, 4, "dec_sat_0");
        n_cmp++;
        if (x_a !== 10'd0) begin
            n_err++;
            $display("FAIL dec_sat_final: got x=%0d, required 0", x_a);
        end
    endtask

    task automatic test_latency;
        int n = 0;
        int lat = 0;
        exp_t e;
        xi = 1; xd = 0; yi = 1; yd = 0; step = 3'd1;
        mx = mx + 1; my = my + 1;
        e.x = 10'(mx); e.y = 9'(my); e.blk = 2'b00;
        sb_a.push_back(e);
        do begin @(negedge clk); n++; end while (!busy_a && n < 50);
        do begin @(negedge clk); lat++; end while (!done_a && lat < 50);
        e = sb_a.pop_front();
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL latency: got busy-to-done %0d cycles, required 5 (done at tick+6)", lat);
        end
        n_cmp++;
        if ({x_a, y_a, blk_a} !== e) begin
            n_err++;
            $display("FAIL latency_pos: got x=%0d y=%0d, required x=%0d y=%0d", x_a, y_a, e.x, e.y);
        end
    endtask

    task automatic test_wall_slide;
        do_move_a(1, 0, 1, 0, 7, "wall_prep1");
        do_move_a(1, 0, 1, 0, 2, "wall_prep2");
        wall_a_en = 1'b1;
        xq_cnt = 0;
        do_move_a(1, 0, 1, 0, 3, "wall_slide");
        n_cmp++;
        if ({x_a, y_a, blk_a} !== {10'd10, 9'd13, 2'b01}) begin
            n_err++;
            $display("FAIL wall_slide_final: got x=%0d y=%0d blk=%b, required x=10 y=13 blk=01", x_a, y_a, blk_a);
        end
        n_cmp++;
        if (xq_cnt == 0) begin
            n_err++;
            $display("FAIL wall_x_query: got %0d X-query cycles, required nonzero", xq_cnt);
        end
        wall_a_en = 1'b0;
    endtask

    task automatic test_both_dirs;
        xq_cnt = 0;
        do_move_a(1, 1, 0, 0, 5, "both_dirs");
        n_cmp++;
        if (xq_cnt != 0) begin
            n_err++;
            $display("FAIL both_dirs_no_query: got %0d X-query cycles, required 0", xq_cnt);
        end
    endtask

    task automatic test_saturate;
        goto_a(637, 100);
        do_move_a(1, 0, 0, 0, 4, "sat_639");
        do_move_a(1, 0, 0, 0, 4, "sat_hold");
        n_cmp++;
        if (x_a !== 10'd639) begin
            n_err++;
            $display("FAIL sat_final: got x=%0d, required 639", x_a);
        end
    endtask

    task automatic test_overrun;
        exp_t e, got;
        int   n;
        n_cmp++;
        if (ovr_b !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_initial: got %b, required 0", ovr_b);
        end
        // Align to a null-evaluation pulse so the next tick samples the new request.
        n = 0;
        do begin @(negedge clk); n++; end while (!done_b && n < 50);
        xi_b = 1'b1; step_b = 3'd1;
        for (int i = 0; i < 4; i++) begin
            bit bx = 0;
            if (bxm + 1 == 4) bx = 1; else bxm = bxm + 1;
            e.x = 10'(bxm); e.y = 9'd0; e.blk = {1'b0, bx};
            sb_b.push_back(e);
        end
        while (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            n = 0;
            do begin @(negedge clk); n++; end while (!done_b && n < 200);
            got = {x_b, y_b, blk_b};
            n_cmp++;
            if (!done_b || got !== e) begin
                n_err++;
                $display("FAIL overrun_step: got done=%b x=%0d blk=%b, required x=%0d blk=%b",
                         done_b, x_b, blk_b, e.x, e.blk);
            end
        end
        n_cmp++;
        if (ovr_b !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_flag: got %b, required 1", ovr_b);
        end
        xi_b = 1'b0;
    endtask

    task automatic test_reset_mid;
        int  n = 0;
        bit  saw_done = 0;
        xi = 0; xd = 1; yi = 0; yd = 0; step = 3'd2;
        do begin @(negedge clk); n++; end while (!(busy_a && col_a !== x_a) && n < 50);
        @(negedge clk);                     // X_WAIT
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({x_a, y_a, busy_a, done_a, blk_a} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async: got x=%0d y=%0d busy=%b done=%b blk=%b, required 0",
                     x_a, y_a, busy_a, done_a, blk_a);
        end
        xd = 0; step = 3'd0;
        repeat (3) begin @(negedge clk); if (done_a) saw_done = 1; end
        n_cmp++;
        if (saw_done || ovr_b !== 1'b0 || x_b !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: got done_seen=%b ovr_b=%b x_b=%0d, required 0/0/0",
                     saw_done, ovr_b, x_b);
        end
        rst_n = 1'b1;
        mx = 0; my = 0;
        do_move_a(1, 0, 0, 0, 1, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_tick();
        test_basic();
        test_dec_sat();
        test_latency();
        test_wall_slide();
        test_both_dirs();
        test_saturate();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
